// File: rtl/ps2_keyevent.sv
`default_nettype none
// ============================================================================
// Module  : ps2_keyevent
// Brief   : PS/2 scan-code set 2 prefix folder, response filter and
//           show-ahead key-event FIFO for the CPU register interface.
// Revision: 1.0 - initial release
// ============================================================================
module ps2_keyevent #(
    parameter int FIFO_AW     = 3,
    parameter int TIMEOUT_CYC = 1000000
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               rbyte_ready,
    input  logic [7:0]         rbyte,
    output logic               ev_valid,
    output logic [9:0]         ev_data,
    input  logic               ev_rd,
    output logic [FIFO_AW:0]   ev_count,
    output logic               overflow,
    input  logic               ovf_clr,
    output logic               bat_ok,
    output logic               kbd_err,
    output logic               ack_p,
    output logic               resend_p,
    output logic               seq_err_p
);

    localparam int               c_NENT  = 2 ** FIFO_AW;
    localparam logic [FIFO_AW:0] c_DEPTH = (FIFO_AW + 1)'(c_NENT);
    localparam int               c_TCW   = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [c_TCW-1:0] c_TLAST = c_TCW'(TIMEOUT_CYC - 1);

    localparam logic [7:0] c_E0 = 8'hE0;
    localparam logic [7:0] c_E1 = 8'hE1;
    localparam logic [7:0] c_F0 = 8'hF0;
    localparam logic [7:0] c_AA = 8'hAA;
    localparam logic [7:0] c_FC = 8'hFC;
    localparam logic [7:0] c_00 = 8'h00;
    localparam logic [7:0] c_FF = 8'hFF;
    localparam logic [7:0] c_FA = 8'hFA;
    localparam logic [7:0] c_FE = 8'hFE;
    localparam logic [7:0] c_EE = 8'hEE;
    localparam logic [7:0] c_LSHIFT = 8'h12;
    localparam logic [7:0] c_RSHIFT = 8'h59;
    localparam logic [7:0] c_PAUSE  = 8'h77;
    localparam logic [2:0] c_PAUSE_LEN = 3'd6;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_E0    = 3'd1,
        ST_F0    = 3'd2,
        ST_E0F0  = 3'd3,
        ST_PAUSE = 3'd4
    } state_t;

    // Parser registers
    state_t             r_state;
    logic [2:0]         r_pcnt;
    logic [c_TCW-1:0]   r_tcnt;
    logic               r_ack;
    logic               r_resend;
    logic               r_seqerr;
    logic               r_bat;
    logic               r_kerr;
    logic               r_ovf;

    // FIFO registers
    logic [9:0]         r_mem [c_NENT];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;

    // Decode results
    state_t             w_nstate;
    logic               w_push;
    logic [9:0]         w_push_ev;
    logic               w_ack;
    logic               w_resend;
    logic               w_seqerr;
    logic               w_bat_set;
    logic               w_kerr_set;
    logic               w_pause_ld;
    logic               w_is_prefix;
    logic               w_is_shift;

    // FIFO control
    logic               w_full;
    logic               w_pop;
    logic               w_wr;
    logic               w_drop;

    assign w_is_prefix = (rbyte == c_E0) || (rbyte == c_E1) || (rbyte == c_F0);
    assign w_is_shift  = (rbyte == c_LSHIFT) || (rbyte == c_RSHIFT);

    always_comb begin
        w_nstate   = r_state;
        w_push     = 1'b0;
        w_push_ev  = {2'b00, rbyte};
        w_ack      = 1'b0;
        w_resend   = 1'b0;
        w_seqerr   = 1'b0;
        w_bat_set  = 1'b0;
        w_kerr_set = 1'b0;
        w_pause_ld = 1'b0;
        if (rbyte_ready) begin
            case (r_state)
                ST_IDLE: begin
                    case (rbyte)
                        c_E0: w_nstate = ST_E0;
                        c_F0: w_nstate = ST_F0;
                        c_E1: begin
                            w_nstate   = ST_PAUSE;
                            w_pause_ld = 1'b1;
                        end
                        c_AA:             w_bat_set  = 1'b1;
                        c_FC, c_00, c_FF: w_kerr_set = 1'b1;
                        c_FA:             w_ack      = 1'b1;
                        c_FE:             w_resend   = 1'b1;
                        c_EE: begin
                        end
                        default: begin
                            w_push    = 1'b1;
                            w_push_ev = {2'b00, rbyte};
                        end
                    endcase
                end
                ST_E0: begin
                    if (rbyte == c_F0) begin
                        w_nstate = ST_E0F0;
                    end else if (rbyte == c_E0) begin
                        w_nstate = ST_E0;
                    end else if (w_is_shift) begin
                        // Fake shifts wrapped around extended keys carry no key information
                        w_nstate = ST_IDLE;
                    end else begin
                        w_push    = 1'b1;
                        w_push_ev = {2'b01, rbyte};
                        w_nstate  = ST_IDLE;
                    end
                end
                ST_F0: begin
                    w_nstate = ST_IDLE;
                    if (w_is_prefix) begin
                        w_seqerr = 1'b1;
                    end else begin
                        w_push    = 1'b1;
                        w_push_ev = {2'b10, rbyte};
                    end
                end
                ST_E0F0: begin
                    w_nstate = ST_IDLE;
                    if (w_is_prefix) begin
                        w_seqerr = 1'b1;
                    end else if (!w_is_shift) begin
                        w_push    = 1'b1;
                        w_push_ev = {2'b11, rbyte};
                    end
                end
                ST_PAUSE: begin
                    if (r_pcnt == 3'd0) begin
                        w_push    = 1'b1;
                        w_push_ev = {2'b01, c_PAUSE};
                        w_nstate  = ST_IDLE;
                    end
                end
                default: w_nstate = ST_IDLE;
            endcase
        end else if ((r_state != ST_IDLE) && (r_tcnt == c_TLAST)) begin
            w_seqerr = 1'b1;
            w_nstate = ST_IDLE;
        end
    end

    assign w_full = (r_count == c_DEPTH);
    assign w_pop  = ev_rd && (r_count != '0);
    assign w_wr   = w_push && (!w_full || w_pop);
    assign w_drop = w_push && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_pcnt   <= 3'd0;
            r_tcnt   <= '0;
            r_ack    <= 1'b0;
            r_resend <= 1'b0;
            r_seqerr <= 1'b0;
            r_bat    <= 1'b0;
            r_kerr   <= 1'b0;
            r_ovf    <= 1'b0;
        end else begin
            r_state  <= w_nstate;
            r_ack    <= w_ack;
            r_resend <= w_resend;
            r_seqerr <= w_seqerr;

            if (w_pause_ld) begin
                r_pcnt <= c_PAUSE_LEN;
            end else if (w_nstate != ST_PAUSE) begin
                r_pcnt <= 3'd0;
            end else if (rbyte_ready) begin
                r_pcnt <= r_pcnt - 3'd1;
            end

            // Holds the number of byte-free cycles seen so far in the current sequence
            if (w_nstate == ST_IDLE) begin
                r_tcnt <= '0;
            end else if (rbyte_ready) begin
                r_tcnt <= c_TCW'(1);
            end else if (r_tcnt != c_TLAST) begin
                r_tcnt <= r_tcnt + 1'b1;
            end

            if (w_kerr_set) begin
                r_bat <= 1'b0;
            end else if (w_bat_set) begin
                r_bat <= 1'b1;
            end

            if (w_kerr_set) begin
                r_kerr <= 1'b1;
            end else if (ovf_clr) begin
                r_kerr <= 1'b0;
            end

            if (w_drop) begin
                r_ovf <= 1'b1;
            end else if (ovf_clr) begin
                r_ovf <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < c_NENT; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_wr) begin
                r_mem[r_wptr] <= w_push_ev;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_wr, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    assign ev_valid  = (r_count != '0);
    assign ev_data   = r_mem[r_rptr];
    assign ev_count  = r_count;
    assign overflow  = r_ovf;
    assign bat_ok    = r_bat;
    assign kbd_err   = r_kerr;
    assign ack_p     = r_ack;
    assign resend_p  = r_resend;
    assign seq_err_p = r_seqerr;

endmodule
`default_nettype wire

// File: tb/tb_ps2_keyevent.sv
`default_nettype none
// ============================================================================
// Module  : tb_ps2_keyevent
// Brief   : Scoreboard bench for ps2_keyevent with a sequence-level key model.
// Revision: 1.0 - initial release
// ============================================================================
module tb_ps2_keyevent;

    localparam int AW    = 3;
    localparam int DEPTH = 2 ** AW;
    localparam int TCYC  = 100;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rbyte_ready = 1'b0;
    logic [7:0]    rbyte = 8'h00;
    logic          ev_valid;
    logic [9:0]    ev_data;
    logic          ev_rd = 1'b0;
    logic [AW:0]   ev_count;
    logic          overflow;
    logic          ovf_clr = 1'b0;
    logic          bat_ok;
    logic          kbd_err;
    logic          ack_p;
    logic          resend_p;
    logic          seq_err_p;

    ps2_keyevent #(.FIFO_AW(AW), .TIMEOUT_CYC(TCYC)) dut (
        .clk         (clk),
        .rst         (rst),
        .rbyte_ready (rbyte_ready),
        .rbyte       (rbyte),
        .ev_valid    (ev_valid),
        .ev_data     (ev_data),
        .ev_rd       (ev_rd),
        .ev_count    (ev_count),
        .overflow    (overflow),
        .ovf_clr     (ovf_clr),
        .bat_ok      (bat_ok),
        .kbd_err     (kbd_err),
        .ack_p       (ack_p),
        .resend_p    (resend_p),
        .seq_err_p   (seq_err_p)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    // Reference model: pending prefix bytes, queued events, popped events awaiting check
    logic [7:0] seq[$];
    logic [9:0] mq[$];
    logic [9:0] sb[$];
    int idle = 0;

    logic nx_ack = 0, nx_res = 0, nx_seq = 0, nx_bat = 0, nx_kerr = 0, nx_ovf = 0, nx_rstd = 0;
    logic cur_ack = 0, cur_res = 0, cur_seq = 0, cur_bat = 0, cur_kerr = 0, cur_ovf = 0, cur_rstd = 0;
    int   cur_count = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, want %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Decode one received byte at the level of whole scan-code sequences
    task automatic model_byte(input logic [7:0] b, output logic has, output logic [9:0] ev,
                              output logic kset);
        logic ext, brk;
        has  = 1'b0;
        ev   = '0;
        kset = 1'b0;
        seq.push_back(b);
        idle = 0;
        if (seq[0] == 8'hE1) begin
            if (seq.size() == 8) begin
                has = 1'b1;
                ev  = 10'h177;
                seq.delete();
            end
        end else if (seq.size() == 1) begin
            if (b != 8'hE0 && b != 8'hF0) begin
                seq.delete();
                case (b)
                    8'hAA:               nx_bat = 1'b1;
                    8'hFC, 8'h00, 8'hFF: begin kset = 1'b1; nx_bat = 1'b0; end
                    8'hFA:               nx_ack = 1'b1;
                    8'hFE:               nx_res = 1'b1;
                    8'hEE:               begin end
                    default:             begin has = 1'b1; ev = {2'b00, b}; end
                endcase
            end
        end else begin
            ext = (seq[0] == 8'hE0);
            brk = 1'b0;
            for (int i = 0; i < seq.size() - 1; i++)
                if (seq[i] == 8'hF0) brk = 1'b1;
            if (ext && !brk && b == 8'hE0) begin
                void'(seq.pop_back());
            end else if (ext && !brk && b == 8'hF0) begin
            end else begin
                seq.delete();
                if (brk && (b == 8'hE0 || b == 8'hE1 || b == 8'hF0)) nx_seq = 1'b1;
                else if (ext && (b == 8'h12 || b == 8'h59)) begin end
                else begin has = 1'b1; ev = {brk, ext, b}; end
            end
        end
    endtask

    // One clock cycle of stimulus; the model predicts outputs visible next cycle
    task automatic step(input logic rdy, input logic [7:0] b, input logic rd,
                        input logic clr, input logic rs);
        logic has, kset, oset;
        logic [9:0] ev;
        @(posedge clk);
        #1;
        cur_ack = nx_ack; cur_res = nx_res; cur_seq = nx_seq;
        cur_bat = nx_bat; cur_kerr = nx_kerr; cur_ovf = nx_ovf; cur_rstd = nx_rstd;
        cur_count = mq.size();
        rst = rs; rbyte_ready = rdy; rbyte = rdy ? b : 8'($urandom);
        ev_rd = rd; ovf_clr = clr;
        nx_rstd = rs;
        nx_ack = 1'b0; nx_res = 1'b0; nx_seq = 1'b0;
        if (rs) begin
            mq.delete(); seq.delete(); idle = 0;
            nx_bat = 1'b0; nx_kerr = 1'b0; nx_ovf = 1'b0;
        end else begin
            has = 1'b0; kset = 1'b0; oset = 1'b0; ev = '0;
            if (rd && mq.size() != 0) sb.push_back(mq.pop_front());
            if (rdy) begin
                model_byte(b, has, ev, kset);
            end else if (seq.size() != 0) begin
                idle++;
                if (idle == TCYC - 1) begin
                    nx_seq = 1'b1;
                    seq.delete();
                end
            end
            if (has) begin
                if (mq.size() < DEPTH) mq.push_back(ev);
                else oset = 1'b1;
            end
            nx_ovf  = oset | (nx_ovf & ~clr);
            nx_kerr = kset | (nx_kerr & ~clr);
        end
    endtask

    task automatic send(input logic [7:0] b);
        step(1'b1, b, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic idle_n(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic drain();
        for (int i = 0; i < DEPTH + 4; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
    endtask

    // Monitor: compares every cycle and checks each popped head against the scoreboard
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ev_count", 32'(ev_count), 32'(cur_count));
            chk("ev_valid", 32'(ev_valid), 32'(cur_count != 0));
            chk("pulses{ack,resend,seq_err}", 32'({ack_p, resend_p, seq_err_p}),
                32'({cur_ack, cur_res, cur_seq}));
            chk("sticky{bat_ok,kbd_err,overflow}", 32'({bat_ok, kbd_err, overflow}),
                32'({cur_bat, cur_kerr, cur_ovf}));
            if (cur_rstd) chk("reset ev_data", 32'(ev_data), 32'h0);
            if (ev_rd && ev_valid && !rst) begin
                if (sb.size() == 0) chk("unexpected pop", 32'(ev_data), 32'h3FF);
                else chk("ev_data", 32'(ev_data), 32'(sb.pop_front()));
            end
        end
    end

    logic [7:0] codes [6] = '{8'h1C, 8'h12, 8'h59, 8'h7C, 8'h77, 8'h14};
    logic [7:0] resps [7] = '{8'hAA, 8'hFC, 8'h00, 8'hFF, 8'hFA, 8'hFE, 8'hEE};

    initial begin
        logic [7:0] b;
        int r, gap;
        for (int i = 0; i < 3; i++) step(1'b1, 8'h1C, 1'b1, 1'b0, 1'b1);
        chk_en = 1'b1;

        send(8'h1C); send(8'hF0); send(8'h1C);
        idle_n(2); drain();

        send(8'hE0); send(8'h12); send(8'hE0); send(8'h7C);
        send(8'hE0); send(8'hF0); send(8'h7C); send(8'hE0); send(8'hF0); send(8'h12);
        idle_n(1); drain();

        send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
        send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
        send(8'h1C); idle_n(1); drain();

        send(8'hAA); idle_n(1); send(8'hFA); idle_n(1); send(8'hFE); idle_n(1);
        send(8'hFC); idle_n(1); step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); idle_n(1);

        for (int i = 1; i <= 9; i++) send(8'(i));
        idle_n(1); step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0); drain();
        for (int i = 1; i <= 8; i++) send(8'(i + 16));
        step(1'b1, 8'h2A, 1'b1, 1'b0, 1'b0);
        idle_n(1); drain();

        send(8'hE0); idle_n(TCYC + 5); send(8'h1C); drain();
        send(8'hF0); step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1); idle_n(2); send(8'h1C); drain();

        for (int n = 0; n < 4000; n++) begin
            gap = ($urandom_range(0, 59) == 0) ? $urandom_range(TCYC - 3, TCYC + 3)
                                               : $urandom_range(0, 2);
            for (int g = 0; g < gap; g++)
                step(1'b0, 8'h00, 1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 63) == 0), 1'b0);
            r = $urandom_range(0, 19);
            if (r < 6)       b = codes[$urandom_range(0, 5)];
            else if (r == 6) b = 8'hE0;
            else if (r == 7) b = 8'hF0;
            else if (r == 8) b = 8'hE1;
            else if (r < 11) b = resps[$urandom_range(0, 6)];
            else             b = 8'($urandom);
            step(1'b1, b, 1'($urandom_range(0, 9) < 4), 1'($urandom_range(0, 63) == 0),
                 1'($urandom_range(0, 499) == 0));
        end

        drain();
        idle_n(2);
        @(negedge clk);
        chk("scoreboard empty", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/ps2_keyevent.md
# ps2_keyevent

Scan-code set 2 decoder and event buffer that sits directly downstream of the PS/2 byte receiver. It consumes the receiver's one-cycle `rbyte_ready` strobe and `rbyte` byte, folds the E0/F0/E1 prefix sequences into single key events, filters keyboard response bytes into status outputs, and queues events in a show-ahead FIFO. The CPU-side register interface drains the FIFO.

## Interface
- `FIFO_AW`, 3: FIFO address width; depth = 2**FIFO_AW events.
- `TIMEOUT_CYC`, 1000000: `clk` cycles with no byte before a partial prefix sequence is abandoned.

Ports:
- `clk`  in  1  system clock, same domain as the receiver.
- `rst`  in  1  synchronous, active-high reset.
- `rbyte_ready`  in  1  one-cycle strobe, byte valid.
- `rbyte`  in  8  received byte, valid only with `rbyte_ready`.
- `ev_valid`  out  1  FIFO non-empty.
- `ev_data`  out  10  head event `{brk, ext, code[7:0]}`.
- `ev_rd`  in  1  pop head; ignored when `ev_valid`=0.
- `ev_count`  out  FIFO_AW+1  events currently queued.
- `overflow`  out  1  sticky: an event was dropped because the FIFO was full.
- `ovf_clr`  in  1  clears `overflow`.
- `bat_ok`  out  1  sticky: the last self-test result was 0xAA.
- `kbd_err`  out  1  sticky: 0xFC, 0x00 or 0xFF was received. Cleared by `ovf_clr`.
- `ack_p`  out  1  one-cycle pulse on 0xFA.
- `resend_p`  out  1  one-cycle pulse on 0xFE.
- `seq_err_p`  out  1  one-cycle pulse when a partial sequence is abandoned.

## Operation
- A byte is processed only on a cycle with `rbyte_ready`=1. `rbyte` is sampled on that cycle.

Parser states:
- **IDLE**
  - E0 → E0.
  - F0 → F0.
  - E1 → PAUSE, with `pcnt`=6.
  - AA: set `bat_ok`.
  - FC, 00 or FF: set `kbd_err`, clear `bat_ok`.
  - FA: pulse `ack_p`.
  - FE: pulse `resend_p`.
  - EE: ignored.
  - Any other byte b: push `{0,0,b}`.
- **E0**
  - F0 → E0F0.
  - E0: stay in E0.
  - 12 or 59 (fake shift): drop, → IDLE.
  - Other b: push `{0,1,b}`, → IDLE.
- **F0**
  - E0, E1 or F0: `seq_err_p`, drop, → IDLE.
  - Other b: push `{1,0,b}`, → IDLE.
- **E0F0**
  - 12 or 59: drop, → IDLE.
  - E0, E1 or F0: `seq_err_p`, → IDLE.
  - Other b: push `{1,1,b}`, → IDLE.
- **PAUSE**
  - Each byte decrements `pcnt`; content is not checked.
  - On the byte where `pcnt`=0: push `{0,1,8'h77}` (Pause make; no break is ever generated), → IDLE.
- **Timeout:** in any state other than IDLE, a cycle counter runs and reloads on every `rbyte_ready`. On reaching TIMEOUT_CYC−1: `seq_err_p`, → IDLE, partial sequence discarded.

FIFO:
- Show-ahead: `ev_data` always shows the head entry when `ev_valid`=1. It is don't-care when empty.
- Push when full:
  - With `ev_rd`=1 on the same cycle: push and pop both succeed, count unchanged.
  - Otherwise: event dropped, `overflow` set.
- Pop on empty: no effect.
- Pointers are FIFO_AW bits and wrap modulo depth. `ev_count` = 0..2**FIFO_AW.
- `overflow`/`kbd_err` set and `ovf_clr` on the same cycle: set wins.

Reset:
- State IDLE, `pcnt`=0, timeout counter 0, FIFO empty.
- All outputs 0 (`ev_data` 0).
- `rbyte_ready` during `rst` is ignored.
- `rst` mid-sequence discards the sequence with no `seq_err_p`.

## Timing
- Everything is registered. An event completing on byte cycle N is written at edge N. `ev_valid` and `ev_data` reflect it from cycle N+1 if the FIFO was empty.
- `ev_rd` at cycle N: next entry (or `ev_valid`=0) from cycle N+1. `ev_count` updates on the same edge.
- `ack_p`, `resend_p`, `seq_err_p` are high for exactly cycle N+1 after the triggering byte or timeout.
- Sticky flags are visible from N+1.
- Back-to-back `rbyte_ready` on consecutive cycles must be handled, one byte per cycle. The receiver never does this, but the bench does.
- Timeout: `seq_err_p` asserts TIMEOUT_CYC cycles after the last byte of the partial sequence.

## Test plan
- **Basic make/break:** bytes 1C, F0 1C → two events `10'h01C`, `10'h21C` in order. `ev_count` reads 2 before any read.
- **Extended plus fake shift:** E0 12 E0 7C, then E0 F0 7C E0 F0 12 → exactly two events `10'h17C` and `10'h37C`.
- **Pause:** E1 14 77 E1 F0 14 F0 77 → one event `10'h177`, parser back in IDLE. A following 1C → `10'h01C`.
- **Responses:** AA → `bat_ok`=1, no event. FA → `ack_p` for one cycle. FE → `resend_p`. FC → `kbd_err`=1, `bat_ok`=0. `ovf_clr` → `kbd_err`=0.
- **Overflow:** FIFO_AW=3; push 9 makes with no reads → `ev_count`=8, `overflow`=1, the first 8 codes are read back in order. Push at full with simultaneous `ev_rd` → no overflow.
- **Timeout/reset:** TIMEOUT_CYC=100; E0 then idle → `seq_err_p` at 100 cycles, next 1C → `10'h01C`. Assert `rst` after F0 → FIFO empty, no `seq_err_p`, next 1C → `10'h01C`.
